// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square wave in clk cycles
module period_meter #(
    parameter int W       = 26,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout
);
    typedef enum logic {IDLE, MEAS} state_t;

    // Compared at 64 bits so a TIMEOUT beyond the counter range can never alias to a match.
    localparam logic [63:0] LAST = 64'(TIMEOUT - 1);

    state_t       state, state_nx;
    logic         s1, s2, s3;
    logic         rise, fall;
    logic         meas_done, meas_fall, expire;
    logic [W-1:0] cnt, hi_cnt, cnt_inc;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign cnt_inc = (&cnt) ? cnt : cnt + W'(1);

    // Two-flop synchronizer plus delay flop; both edges see the same 3-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) {s1, s2, s3} <= 3'b000;
        else     {s1, s2, s3} <= {sig_in, s1, s2};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: first rise arms the measurement, an expired count disarms it.
    always_comb begin
        state_nx = (state == IDLE) ? (rise ? MEAS : IDLE) : (expire ? IDLE : MEAS);
    end

    // Per-state qualifiers; a rise on the expiry cycle suppresses the timeout.
    always_comb begin
        meas_done = (state == MEAS) && rise;
        meas_fall = (state == MEAS) && fall;
        expire    = (state == MEAS) && !rise && (64'(cnt) == LAST);
    end

    // Counters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cnt     <= rise ? '0 : cnt_inc;
            hi_cnt  <= rise ? '0 : (meas_fall ? cnt_inc : hi_cnt);
            valid   <= meas_done;
            timeout <= meas_done ? 1'b0 : (expire ? 1'b1 : timeout);
            if (meas_done) begin
                period    <= cnt_inc;
                high_time <= hi_cnt;
            end
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed table-driven bench for period_meter (W=26 and W=4 instances)
module tb_period_meter;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst, sig, sig4;
    logic [25:0] period, high_time;
    logic        valid, timeout;
    logic [3:0]  period4, high_time4;
    logic        valid4, timeout4;

    int errors = 0;
    int checks = 0;
    int qp[$], qh[$], q4p[$], q4h[$];

    typedef struct {
        int hi;
        int lo;
        int nv;
        int p;
        int h;
    } vec_t;

    vec_t tab[9];

    always #5 clk = ~clk;

    period_meter #(.W(26), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sig_in(sig),
        .period(period), .high_time(high_time), .valid(valid), .timeout(timeout)
    );

    period_meter #(.W(4), .TIMEOUT(TO)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig4),
        .period(period4), .high_time(high_time4), .valid(valid4), .timeout(timeout4)
    );

    // Record every valid pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            qp.push_back(int'(period));
            qh.push_back(int'(high_time));
        end
        if (valid4 === 1'b1) begin
            q4p.push_back(int'(period4));
            q4h.push_back(int'(high_time4));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wave(input bit four, input int hi, input int lo);
        if (four) sig4 = 1'b1; else sig = 1'b1;
        cyc(hi);
        if (four) sig4 = 1'b0; else sig = 1'b0;
        cyc(lo);
    endtask

    task automatic expect_q(input string name, input bit four, input int nv, input int p, input int h);
        int n_got;
        n_got = four ? q4p.size() : qp.size();
        chk({name, " valid count"}, n_got, nv);
        if (nv > 0 && n_got > 0) begin
            chk({name, " period"}, four ? q4p[0] : qp[0], p);
            chk({name, " high_time"}, four ? q4h[0] : qh[0], h);
        end
        if (four) begin
            q4p.delete();
            q4h.delete();
        end else begin
            qp.delete();
            qh.delete();
        end
    endtask

    initial begin
        tab[0] = '{8, 12, 0, 0, 0};
        tab[1] = '{8, 12, 1, 20, 8};
        tab[2] = '{8, 12, 1, 20, 8};
        tab[3] = '{8, 12, 1, 20, 8};
        tab[4] = '{8, 12, 1, 20, 8};
        tab[5] = '{20, 20, 1, 20, 8};
        tab[6] = '{20, 20, 1, 40, 20};
        tab[7] = '{5, 35, 1, 40, 20};
        tab[8] = '{5, 35, 1, 40, 5};

        rst  = 1'b1;
        sig  = 1'b0;
        sig4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig  = ~sig;
            sig4 = ~sig4;
            cyc(1);
        end
        chk("reset period", period, 0);
        chk("reset high_time", high_time, 0);
        chk("reset valid", valid, 0);
        chk("reset timeout", timeout, 0);
        chk("reset period4", period4, 0);
        chk("reset high_time4", high_time4, 0);
        chk("reset valid4", valid4, 0);
        rst  = 1'b0;
        sig  = 1'b0;
        sig4 = 1'b0;
        cyc(5);
        expect_q("post reset", 1'b0, 0, 0, 0);
        expect_q("post reset w4", 1'b1, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            wave(1'b0, tab[i].hi, tab[i].lo);
            expect_q($sformatf("row%0d", i), 1'b0, tab[i].nv, tab[i].p, tab[i].h);
            chk($sformatf("row%0d timeout", i), timeout, 0);
        end

        sig = 1'b1;
        cyc(4);
        sig = 1'b0;
        cyc(98);
        chk("timeout early", timeout, 0);
        cyc(1);
        chk("timeout at 100", timeout, 1);
        chk("timeout period held", period, 40);
        chk("timeout high_time held", high_time, 5);
        expect_q("timeout rise", 1'b0, 1, 40, 5);

        wave(1'b0, 6, 14);
        expect_q("rearm rise", 1'b0, 0, 0, 0);
        chk("rearm timeout sticky", timeout, 1);
        wave(1'b0, 6, 14);
        expect_q("second rise", 1'b0, 1, 20, 6);
        chk("second rise timeout clear", timeout, 0);

        wave(1'b0, 10, 90);
        expect_q("pre coincide", 1'b0, 1, 20, 6);
        sig = 1'b1;
        cyc(4);
        sig = 1'b0;
        cyc(10);
        expect_q("coincide", 1'b0, 1, TO, 10);
        chk("coincide timeout", timeout, 0);

        wave(1'b1, 20, 10);
        expect_q("w4 first", 1'b1, 0, 0, 0);
        wave(1'b1, 20, 10);
        expect_q("w4 sat", 1'b1, 1, 15, 15);
        sig4 = 1'b1;
        cyc(10);
        expect_q("w4 sat2", 1'b1, 1, 15, 15);
        rst = 1'b1;
        cyc(2);
        chk("midrst period4", period4, 0);
        chk("midrst high_time4", high_time4, 0);
        chk("midrst valid4", valid4, 0);
        chk("midrst period", period, 0);
        rst = 1'b0;
        cyc(5);
        expect_q("midrst no valid", 1'b1, 0, 0, 0);
        sig4 = 1'b0;
        cyc(10);
        sig4 = 1'b1;
        cyc(5);
        expect_q("after midrst", 1'b1, 1, 15, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The block SHALL have parameter W, default 26, giving the width of the measurement counters and outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 50_000_000, giving the clk cycles without a rising edge before a timeout is declared.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have port sig_in, input, 1, asynchronous slow square wave to measure (e.g. a divided LED clock).
REQ-006 The block SHALL have port period, output, W, clk cycles between the last two rising edges of sig_in.
REQ-007 The block SHALL have port high_time, output, W, clk cycles sig_in was high within that period.
REQ-008 The block SHALL have port valid, output, 1, one-cycle pulse when period/high_time update.
REQ-009 The block SHALL have port timeout, output, 1, sticky flag: no rising edge within TIMEOUT cycles.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus one delay flop (s3).
- rise = s2 & ~s3; fall = ~s2 & s3.
- Edge detect latency SHALL be fixed at 3 clk cycles for every edge, so it does not bias measurements.
REQ-011 FSM states SHALL be IDLE and MEAS.
- Reset enters IDLE.
- IDLE -> MEAS on rise.
- MEAS -> IDLE on timeout.
- MEAS stays in MEAS on rise.
REQ-012 Free counter cnt (W bits) SHALL clear to 0 on every rise and otherwise increment by 1 per cycle.
- cnt SHALL saturate at 2^W-1; it never wraps.
REQ-013 In MEAS, a fall SHALL latch hi_cnt = cnt+1, saturating.
- A fall in IDLE SHALL be ignored.
REQ-014 In MEAS, a rise SHALL, on the same clock edge:
- load period = cnt+1, saturating;
- load high_time = hi_cnt;
- assert valid for exactly one cycle;
- clear timeout.
REQ-015 The rise in IDLE SHALL only start measurement.
- No valid; period and high_time unchanged.
- The first valid therefore occurs on the second rise.
REQ-016 In MEAS, when cnt reaches TIMEOUT-1 with no rise that cycle:
- the next edge SHALL set timeout = 1 and return to IDLE;
- period and high_time SHALL hold their last values;
- valid SHALL stay 0.
REQ-017 If rise and the timeout condition occur in the same cycle, rise SHALL win: measurement completes as REQ-014 and there is no timeout.
REQ-018 If a rise occurs with no fall seen since the previous rise, high_time SHALL report 0.
- hi_cnt SHALL clear to 0 on every rise.
REQ-019 If sig_in is constant high, a timeout SHALL occur exactly as for constant low.
REQ-020 Arithmetic SHALL be unsigned.
- +1 operations SHALL saturate at 2^W-1.
- Measured period includes both edges' positions, so a 4-cycle square wave reports 4.

Reset
REQ-021 When rst = 1 at a clk edge, the following SHALL be 0: s1, s2, s3, cnt, hi_cnt, period, high_time, valid, timeout.
- The state SHALL be IDLE.
REQ-022 Reset asserted mid-measurement SHALL abort it with no valid pulse.
- After release, two further rising edges are required before the next valid.
REQ-023 sig_in activity during reset SHALL be ignored; the synchronizer SHALL hold 0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: rst high 3 cycles, sig_in toggling -> all outputs 0, no valid.
- Square wave, 8 clk high / 12 clk low, for 5 periods -> valid on 2nd and each later rise; period = 20, high_time = 8 each time.
- Duty change mid-run, 20/20 then 5/35 -> first valid after the change reports 40/20 if the change occurs after a rise; then 40/5.
- sig_in held low after 2 rises, TIMEOUT = 100 -> timeout = 1 exactly 100 cycles after the last rise; period holds its last value; next two rises produce valid and clear timeout.
- Rise coincident with cnt = TIMEOUT-1 -> valid = 1, period = TIMEOUT, timeout stays 0.
- W = 4, wave period 30 -> period = 15 (saturated); rst asserted mid-period -> no valid, outputs 0.
